// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered ALU control decoder:
//   - ALU_*   : 3-bit ALU control codes (zero-extended to CTRL_W by users)
//   - ALUOP_* : decode-stage operation class encodings
//   - skid_state_e : occupancy state of the 2-entry output skid buffer
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLT = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_ctrl_lut.sv
// -----------------------------------------------------------------------------
// alu_ctrl_lut
// Pure combinational map from {aluop, funct} to {ALU control code, illegal}.
// Illegal encodings return ADD with illegal_o=1, so X never propagates.
// Ports:
//   aluop_i   [1:0]          operation class (MEM/BRANCH/RTYPE/ITYPE)
//   funct_i   [FUNCT_W-1:0]  operation select; values >= 8 are illegal
//   ctrl_o    [CTRL_W-1:0]   ALU control code
//   illegal_o                encoding was illegal
// -----------------------------------------------------------------------------
module alu_ctrl_lut
    import alu_pkg::*;
#(
    parameter int FUNCT_W = 4,
    parameter int CTRL_W  = 4
) (
    input  logic [1:0]         aluop_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic               illegal_o
);

    logic       funct_hi;
    logic [2:0] funct_lo;
    logic [2:0] ctrl3;

    // Any bit at weight 8 or above makes funct out of range; the shift form
    // stays valid for every FUNCT_W >= 3.
    assign funct_hi = (funct_i >> 3) != '0;
    assign funct_lo = funct_i[2:0];

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ctrl3     = ALU_ADD;
        illegal_o = 1'b0;
        unique case (aluop_i)
            ALUOP_MEM:    ctrl3 = ALU_ADD;
            ALUOP_BRANCH: ctrl3 = ALU_SUB;
            ALUOP_RTYPE: begin
                if (funct_hi) illegal_o = 1'b1;
                else          ctrl3     = funct_lo;
            end
            ALUOP_ITYPE: begin
                // There is no subtract-immediate; SUB is rejected here.
                if (funct_hi || (funct_lo == ALU_SUB)) illegal_o = 1'b1;
                else                                   ctrl3     = funct_lo;
            end
        endcase
    end

    assign ctrl_o = CTRL_W'(ctrl3);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pipe
// Registered, valid/ready ALU control decoder. Requests are decoded at accept
// time and stored in a 2-entry skid buffer feeding the execute stage. Keeps a
// saturating count of accepted illegal ops.
//
// Optional feature (macro ALU_CTRL_IDLE_GATE_EN):
//   defined   - an idle counter drives alu_clk_en low after 2^IDLE_CNT_W-1
//               idle cycles; in_valid wakes it combinationally.
//   undefined - alu_clk_en is tied to 1 and no counter is built.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid/in_ready, in_aluop, in_funct, in_tag    request side
//   out_valid/out_ready, out_alu_ctrl, out_tag, out_illegal  result side
//   illegal_count  saturating count of accepted illegal ops
//   alu_clk_en     ALU clock-enable hint
// -----------------------------------------------------------------------------
module alu_ctrl_pipe
    import alu_pkg::*;
#(
    parameter int FUNCT_W    = 4,
    parameter int CTRL_W     = 4,
    parameter int TAG_W      = 5,
    parameter int ERR_CNT_W  = 8,
    parameter int IDLE_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_aluop,
    input  logic [FUNCT_W-1:0]   in_funct,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_alu_ctrl,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_illegal,
    output logic [ERR_CNT_W-1:0] illegal_count,
    output logic                 alu_clk_en
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              illegal;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    skid_state_e state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    entry_t      new_ent;

    logic [CTRL_W-1:0]    lut_ctrl;
    logic                 lut_illegal;
    logic                 push;
    logic                 pop;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    alu_ctrl_lut #(
        .FUNCT_W (FUNCT_W),
        .CTRL_W  (CTRL_W)
    ) u_lut (
        .aluop_i   (in_aluop),
        .funct_i   (in_funct),
        .ctrl_o    (lut_ctrl),
        .illegal_o (lut_illegal)
    );

    assign new_ent = '{ctrl: lut_ctrl, illegal: lut_illegal, tag: in_tag};
    assign push    = in_valid & in_ready;
    assign pop     = out_valid & out_ready;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs. The two buffer entries are reset as well,
    // because the head entry drives the outputs directly and must read 0
    // after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic (state plus entry movement)
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    state_d = SKID_ONE;
                    head_d  = new_ent;
                end
            end
            SKID_ONE: begin
                if (push && !pop) begin
                    state_d = SKID_FULL;
                    tail_d  = new_ent;
                end else if (push && pop) begin
                    head_d  = new_ent;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only a pop can occur.
                if (pop) begin
                    state_d = SKID_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs: decoded from registers only, so out_ready never reaches
    // in_ready combinationally.
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q != SKID_FULL);
        out_valid = (state_q != SKID_EMPTY);
    end

    assign out_alu_ctrl = head_q.ctrl;
    assign out_illegal  = head_q.illegal;
    assign out_tag      = head_q.tag;

    // ---------------------------------------------------------------------
    // Saturating illegal-op counter
    // ---------------------------------------------------------------------
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && lut_illegal && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign illegal_count = err_cnt_q;

    // ---------------------------------------------------------------------
    // Idle clock-gating hint
    // ---------------------------------------------------------------------
`ifdef ALU_CTRL_IDLE_GATE_EN
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic                  idle_now;

    assign idle_now = (state_q == SKID_EMPTY) && !in_valid;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (!idle_now)
            idle_cnt_d = '0;
        else if (idle_cnt_q != '1)
            idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) idle_cnt_q <= '0;
        else        idle_cnt_q <= idle_cnt_d;
    end

    // idle_now contains in_valid, so a new request re-enables the clock in
    // the same cycle it appears.
    assign alu_clk_en = !((idle_cnt_q == '1) && idle_now);
`else
    assign alu_clk_en = 1'b1;
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_pipe
// Directed testbench for alu_ctrl_pipe. The driver pushes the hand-computed
// expected result into a scoreboard queue at accept time; a monitor pops and
// compares at every output handshake. Honours ALU_CTRL_IDLE_GATE_EN.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_pipe;

    localparam int FUNCT_W    = 4;
    localparam int CTRL_W     = 4;
    localparam int TAG_W      = 5;
    localparam int ERR_CNT_W  = 8;
    localparam int IDLE_CNT_W = 4;

    localparam logic [1:0] OP_MEM = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_aluop;
    logic [FUNCT_W-1:0]   in_funct;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [CTRL_W-1:0]    out_alu_ctrl;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_illegal;
    logic [ERR_CNT_W-1:0] illegal_count;
    logic                 alu_clk_en;

    alu_ctrl_pipe #(
        .FUNCT_W    (FUNCT_W),
        .CTRL_W     (CTRL_W),
        .TAG_W      (TAG_W),
        .ERR_CNT_W  (ERR_CNT_W),
        .IDLE_CNT_W (IDLE_CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_aluop      (in_aluop),
        .in_funct      (in_funct),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_ctrl  (out_alu_ctrl),
        .out_tag       (out_tag),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count),
        .alu_clk_en    (alu_clk_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic              ill;
        logic [TAG_W-1:0]  tag;
        int                acc;
        bit                lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a transfer completes at the next rising edge whenever
    // out_valid and out_ready are both high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_alu_ctrl", 32'(out_alu_ctrl), 32'(mon_e.ctrl));
                check("out_illegal",  32'(out_illegal),  32'(mon_e.ill));
                check("out_tag",      32'(out_tag),      32'(mon_e.tag));
                if (mon_e.lat) check("latency", cyc, mon_e.acc);
            end
        end
    end

    // Drive one request; called just after a rising edge and returns just
    // after the accepting edge with in_valid still high. 'now' demands
    // acceptance at the first edge and one-cycle presentation.
    task automatic send(input logic [1:0] op, input logic [FUNCT_W-1:0] f,
                        input logic [TAG_W-1:0] t, input logic [CTRL_W-1:0] ec,
                        input logic ei, input bit now);
        exp_t e;
        int   waited = 0;
        in_valid = 1'b1;
        in_aluop = op;
        in_funct = f;
        in_tag   = t;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        if (now) check("in_ready_wait", waited, 0);
        e.ctrl = ec;
        e.ill  = ei;
        e.tag  = t;
        e.acc  = cyc + 1;
        e.lat  = now;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [FUNCT_W-1:0] f;
    logic [TAG_W-1:0]   t;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_aluop  = '0;
        in_funct  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready",  32'(in_ready), 1);
        check("rst_ctrl",      32'(out_alu_ctrl), 0);
        check("rst_tag",       32'(out_tag), 0);
        check("rst_illegal",   32'(out_illegal), 0);
        check("rst_count",     32'(illegal_count), 0);
        check("rst_clk_en",    32'(alu_clk_en), 1);
        @(posedge clk);
        #1;

        // 1: RTYPE funct 0..7 back-to-back, ctrl equals funct
        for (int i = 0; i < 8; i++) begin
            f = FUNCT_W'(i);
            t = TAG_W'(10 + i);
            send(OP_R, f, t, CTRL_W'(i), 1'b0, 1'b1);
        end
        idle(3);
        check("t1_count", 32'(illegal_count), 0);

        // 2: mode decode and illegal flagging
        send(OP_MEM, 4'd5, 5'd1, 4'd0, 1'b0, 1'b1);
        send(OP_BR,  4'd3, 5'd2, 4'd1, 1'b0, 1'b1);
        send(OP_I,   4'd1, 5'd3, 4'd0, 1'b1, 1'b1);
        send(OP_I,   4'd6, 5'd6, 4'd6, 1'b0, 1'b1);
        idle(1);
        check("t2_count1", 32'(illegal_count), 1);
        send(OP_R,   4'd9, 5'd4, 4'd0, 1'b1, 1'b1);
        idle(2);
        check("t2_count2", 32'(illegal_count), 2);

        // 3: back-pressure, FIFO order and stall stability
        out_ready = 1'b0;
        send(OP_R, 4'd2, 5'd3, 4'd2, 1'b0, 1'b0);
        send(OP_R, 4'd4, 5'd4, 4'd4, 1'b0, 1'b0);
        fork
            send(OP_R, 4'd7, 5'd5, 4'd7, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("t3_in_ready_low", 32'(in_ready), 0);
                    check("t3_stall_valid",  32'(out_valid), 1);
                    check("t3_stall_tag",    32'(out_tag), 3);
                    check("t3_stall_ctrl",   32'(out_alu_ctrl), 2);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);

        // 4: illegal counter saturation
        check("t4_count_start", 32'(illegal_count), 2);
        for (int i = 0; i < 260; i++) begin
            f = FUNCT_W'(8 + (i % 8));
            t = TAG_W'(i);
            send(OP_R, f, t, 4'd0, 1'b1, 1'b1);
            if (i == 251) check("t4_count_254", 32'(illegal_count), 254);
        end
        idle(3);
        check("t4_count_sat", 32'(illegal_count), 255);

        // 5: synchronous reset with the buffer full
        out_ready = 1'b0;
        send(OP_R, 4'd3, 5'd1, 4'd3, 1'b0, 1'b0);
        send(OP_R, 4'd5, 5'd2, 4'd5, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_full_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_aluop = OP_R;
        in_funct = 4'd9;
        in_tag   = 5'd31;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_in_ready",  32'(in_ready), 1);
        check("t5_ctrl",      32'(out_alu_ctrl), 0);
        check("t5_tag",       32'(out_tag), 0);
        check("t5_illegal",   32'(out_illegal), 0);
        check("t5_count",     32'(illegal_count), 0);
        @(posedge clk);
        #1;
        send(OP_R, 4'd6, 5'd7, 4'd6, 1'b0, 1'b1);
        send(OP_I, 4'd9, 5'd8, 4'd0, 1'b1, 1'b1);
        idle(2);
        check("t5_count_after", 32'(illegal_count), 1);

        // 6: idle clock-gating hint
`ifdef ALU_CTRL_IDLE_GATE_EN
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("t6_clk_en_14", 32'(alu_clk_en), 1);
        @(posedge clk);
        @(negedge clk);
        check("t6_clk_en_15", 32'(alu_clk_en), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_aluop = OP_R;
        in_funct = 4'd4;
        in_tag   = 5'd9;
        #1;
        check("t6_wake", 32'(alu_clk_en), 1);
        send(OP_R, 4'd4, 5'd9, 4'd4, 1'b0, 1'b1);
        idle(3);
`else
        idle(20);
        @(negedge clk);
        check("t6_clk_en_tied", 32'(alu_clk_en), 1);
        @(posedge clk);
        #1;
`endif

        idle(3);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
